// File: rtl/gpio_in_pkg.sv
// Shared definitions for the gpio_in memory-mapped input port: register
// offsets, the default base address, register-select encoding and decode helper.
package gpio_in_pkg;

    // Default byte address of register 0 (DATA).
    localparam logic [31:0] GPIO_IN_BASE = 32'h0002_0100;

    // Byte offsets of the four registers inside the 16-byte window.
    localparam logic [3:0] GPIO_IN_DATA = 4'h0;
    localparam logic [3:0] GPIO_IN_EDGE = 4'h4;
    localparam logic [3:0] GPIO_IN_RAW  = 4'h8;
    localparam logic [3:0] GPIO_IN_MASK = 4'hC;

    // Word select taken from addr[3:2]; byte lane bits addr[1:0] are ignored.
    typedef enum logic [1:0] {
        REG_DATA = GPIO_IN_DATA[3:2],
        REG_EDGE = GPIO_IN_EDGE[3:2],
        REG_RAW  = GPIO_IN_RAW[3:2],
        REG_MASK = GPIO_IN_MASK[3:2]
    } gpio_in_reg_e;

    // The block claims the whole 16-byte window that shares addr[31:4] with the base.
    function automatic logic gpio_in_hit(input logic [27:0] addr_hi,
                                         input logic [27:0] base_hi);
        return addr_hi == base_hi;
    endfunction

endpackage

// File: rtl/gpio_in_if.sv
// Load/store port between the core's EX/WB path and the gpio_in register file.
// Address and strobes are presented in EX; read data comes back one cycle later.
interface gpio_in_if;

    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [31:0] rd_data;
    logic        rd_hit;

    // Core side: drives the EX-stage access, consumes WB-stage read data.
    modport master (
        output addr,
        output rd_en,
        output wr_en,
        output wr_data,
        input  rd_data,
        input  rd_hit
    );

    // Peripheral side: decodes the access and returns registered read data.
    modport slave (
        input  addr,
        input  rd_en,
        input  wr_en,
        input  wr_data,
        output rd_data,
        output rd_hit
    );

endinterface

// File: rtl/gpio_in_debounce.sv
// Single-bit debouncer: the output level follows the synchronized input only
// after it has differed from the current level for DB_CYCLES consecutive
// cycles. rise_o pulses in the cycle the level is about to go 0->1.
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level_o,
    output logic rise_o
);

    // The counter only ever reaches DB_CYCLES-1 before being cleared, so this width never wraps.
    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 16'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (din != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = din;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Counter and qualified level state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    // Looks at the next level so the sticky edge bit sets on the same clock edge as the level.
    assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/gpio_in.sv
// gpio_in: memory-mapped input port. Synchronizes and debounces external pins,
// latches rising edges in write-1-to-clear sticky bits, and exposes DATA/EDGE/
// RAW/MASK registers to the core's load/store path with one-cycle read latency.
// irq is the registered OR of masked edge bits.
module gpio_in
    import gpio_in_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR = GPIO_IN_BASE,
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_i,
    gpio_in_if.slave         bus,
    output logic             irq
);

    // Two-flop synchronizer stages.
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    // Debounced level and rising-edge pulses from the per-bit debouncers.
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;

    // Register file state.
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;

    // Registered read return and interrupt.
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_hit_q, rd_hit_d;
    logic        irq_q, irq_d;

    // Access decode.
    logic         hit;
    gpio_in_reg_e sel;
    logic         wr_edge;
    logic         wr_mask;
    logic [31:0]  rd_word;

    // Byte-lane address bits and store data above WIDTH carry no meaning here.
    logic unused_bus;
    assign unused_bus = ^{bus.addr[1:0], bus.wr_data};

    // Synchronizer next-state: pin_i -> s1 -> s2.
    always_comb begin
        s1_d = pin_i;
        s2_d = s1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        gpio_in_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (s2_q[i]),
            .level_o(level[i]),
            .rise_o (rise[i])
        );
    end

    // Address decode and write strobes for the two writable registers.
    always_comb begin
        hit     = gpio_in_hit(bus.addr[31:4], BASE_ADDR[31:4]);
        sel     = gpio_in_reg_e'(bus.addr[3:2]);
        wr_edge = bus.wr_en & hit & (sel == REG_EDGE);
        wr_mask = bus.wr_en & hit & (sel == REG_MASK);
    end

    // EDGE/MASK update; a new rising edge beats a same-cycle clear of the same bit.
    always_comb begin
        edge_d = rise | (edge_q & ~(wr_edge ? bus.wr_data[WIDTH-1:0] : {WIDTH{1'b0}}));
        mask_d = wr_mask ? bus.wr_data[WIDTH-1:0] : mask_q;
        irq_d  = |(edge_d & mask_d);
    end

    // Read mux over current (pre-update) register values; unused upper bits read 0.
    always_comb begin
        rd_word = '0;
        unique case (sel)
            REG_DATA: rd_word[WIDTH-1:0] = level;
            REG_EDGE: rd_word[WIDTH-1:0] = edge_q;
            REG_RAW:  rd_word[WIDTH-1:0] = s2_q;
            REG_MASK: rd_word[WIDTH-1:0] = mask_q;
            default:  rd_word = '0;
        endcase
        rd_hit_d  = bus.rd_en & hit;
        rd_data_d = rd_hit_d ? rd_word : 32'h0;
    end

    // Register file, read return and interrupt flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q    <= '0;
            mask_q    <= '0;
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            edge_q    <= edge_d;
            mask_q    <= mask_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_hit  = rd_hit_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_gpio_in.sv
// Testbench for gpio_in with a short debounce window. A behavioural model
// tracks, per pin, how long the synchronized value has held, and derives the
// debounced level, sticky edges, mask, irq and expected read return from that.
module tb_gpio_in;
    import gpio_in_pkg::*;

    localparam int          W    = 8;
    localparam int          DB   = 4;
    localparam logic [31:0] BASE = GPIO_IN_BASE;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pin_i = 8'h00;
    logic       irq;

    gpio_in_if bus();

    gpio_in #(
        .WIDTH    (W),
        .BASE_ADDR(BASE),
        .DB_CYCLES(16'(DB))
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pin_i(pin_i),
        .bus  (bus.slave),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    logic [7:0]  m_s1, m_s2, m_last, m_lvl, m_edge, m_mask;
    int          m_run [8];
    logic [31:0] m_rd_data;
    logic        m_rd_hit, m_irq;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_last = 0; m_lvl = 0; m_edge = 0; m_mask = 0;
        m_rd_data = 0; m_rd_hit = 0; m_irq = 0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    // One clock: predict the effect of the current inputs, advance the DUT, settle.
    task automatic tick();
        logic [7:0]  nl, ne, nm, clr;
        logic        h;
        logic [1:0]  idx;
        logic [31:0] rv;
        for (int i = 0; i < 8; i++) begin
            if (m_run[i] > 0 && m_s2[i] == m_last[i]) m_run[i]++;
            else m_run[i] = 1;
            m_last[i] = m_s2[i];
            nl[i] = (m_s2[i] != m_lvl[i] && m_run[i] >= DB) ? m_s2[i] : m_lvl[i];
        end
        h   = (bus.addr[31:4] == BASE[31:4]);
        idx = bus.addr[3:2];
        case (idx)
            2'd0: rv = {24'h0, m_lvl};
            2'd1: rv = {24'h0, m_edge};
            2'd2: rv = {24'h0, m_s2};
            default: rv = {24'h0, m_mask};
        endcase
        clr = (bus.wr_en && h && idx == 2'd1) ? bus.wr_data : 8'h00;
        ne  = (nl & ~m_lvl) | (m_edge & ~clr);
        nm  = (bus.wr_en && h && idx == 2'd3) ? bus.wr_data : m_mask;
        @(posedge clk);
        m_rd_hit  = bus.rd_en && h;
        m_rd_data = m_rd_hit ? rv : 32'h0;
        m_s2 = m_s1; m_s1 = pin_i;
        m_lvl = nl; m_edge = ne; m_mask = nm;
        m_irq = |(ne & nm);
        #1;
    endtask

    task automatic bus_idle();
        bus.rd_en = 0; bus.wr_en = 0; bus.addr = 32'h0; bus.wr_data = 8'h00;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        bus.rd_en = 1; bus.wr_en = 0; bus.addr = a; bus.wr_data = 8'h00;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
        bus.rd_en = 0; bus.wr_en = 1; bus.addr = a; bus.wr_data = d;
    endtask

    task automatic test_reset();
        rst_n = 0; pin_i = 8'hFF; bus_idle();
        repeat (3) @(posedge clk);
        #1; rst_n = 1; model_reset();
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want %h", bus.rd_data, 32'h0); end
        n_checks++; if (bus.rd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_rd_hit: got %b want 0", bus.rd_hit); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        bus_rd(BASE + GPIO_IN_DATA); tick();
        n_checks++; if (bus.rd_data !== 32'h0 || bus.rd_hit !== 1'b1) begin n_fail++; $display("FAIL reset_data_read: got %h/%b want 0/1", bus.rd_data, bus.rd_hit); end
        pin_i = 8'h00; bus_idle();
        repeat (12) tick();
        bus_wr(BASE + GPIO_IN_EDGE, 8'hFF); tick();
        bus_rd(BASE + GPIO_IN_EDGE); tick();
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_edge_clear: got %h want 0", bus.rd_data); end
        bus_idle();
    endtask

    task automatic test_latency();
        pin_i[0] = 1'b1; bus_rd(BASE + GPIO_IN_DATA);
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++; if (bus.rd_data !== m_rd_data) begin n_fail++; $display("FAIL latency_model k=%0d: got %h want %h", k, bus.rd_data, m_rd_data); end
            if (k == 6) begin
                n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL latency_5cyc: got %h want 0", bus.rd_data); end
            end
            if (k == 7) begin
                n_checks++; if (bus.rd_data !== 32'h1) begin n_fail++; $display("FAIL latency_6cyc: got %h want 1", bus.rd_data); end
            end
        end
        bus_idle();
    endtask

    task automatic test_glitch();
        pin_i = 8'h00; repeat (10) tick();
        bus_wr(BASE + GPIO_IN_EDGE, 8'hFF); tick();
        bus_idle();
        pin_i[0] = 1'b1; repeat (3) tick();
        pin_i[0] = 1'b0; bus_rd(BASE + GPIO_IN_DATA);
        repeat (10) tick();
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL glitch_data: got %h want 0", bus.rd_data); end
        bus_rd(BASE + GPIO_IN_EDGE); tick();
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL glitch_edge: got %h want 0", bus.rd_data); end
        bus_idle();
    endtask

    task automatic test_edge_w1c();
        pin_i = 8'h04; repeat (8) tick();
        bus_rd(BASE + GPIO_IN_EDGE); tick();
        n_checks++; if (bus.rd_data !== 32'h4 || bus.rd_hit !== 1'b1) begin n_fail++; $display("FAIL edge_read: got %h/%b want 4/1", bus.rd_data, bus.rd_hit); end
        bus_wr(BASE + GPIO_IN_EDGE, 8'h04); tick();
        bus_rd(BASE + GPIO_IN_EDGE); tick();
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL edge_w1c: got %h want 0", bus.rd_data); end
        bus_idle(); pin_i = 8'h00; repeat (8) tick();
        pin_i = 8'h04; repeat (5) tick();
        bus_wr(BASE + GPIO_IN_EDGE, 8'h04); tick();
        bus_rd(BASE + GPIO_IN_EDGE); tick();
        n_checks++; if (bus.rd_data !== 32'h4) begin n_fail++; $display("FAIL edge_set_wins: got %h want 4", bus.rd_data); end
        n_checks++; if (bus.rd_data !== m_rd_data) begin n_fail++; $display("FAIL edge_model: got %h want %h", bus.rd_data, m_rd_data); end
        bus_idle();
    endtask

    task automatic test_irq();
        bus_wr(BASE + GPIO_IN_EDGE, 8'hFF); tick();
        bus_wr(BASE + GPIO_IN_MASK, 8'h02); tick();
        bus_idle(); pin_i = 8'h05; repeat (8) tick();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_unmasked_bit: got %b want 0", irq); end
        pin_i = 8'h07;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) begin
                n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", irq); end
            end
            if (k == 6) begin
                n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
            end
        end
        bus_wr(BASE + GPIO_IN_EDGE, 8'h02); tick();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
        bus_idle();
    endtask

    task automatic test_decode();
        bus_rd(BASE + 32'h10); tick();
        n_checks++; if (bus.rd_hit !== 1'b0 || bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL decode_above: got %h/%b want 0/0", bus.rd_data, bus.rd_hit); end
        bus_rd(32'h0001_0000); tick();
        n_checks++; if (bus.rd_hit !== 1'b0 || bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL decode_other: got %h/%b want 0/0", bus.rd_data, bus.rd_hit); end
        bus_wr(BASE + 32'h1C, 8'hFF); tick();
        bus_wr(32'h0001_0004, 8'hFF); tick();
        bus_rd(BASE + GPIO_IN_MASK); tick();
        n_checks++; if (bus.rd_data !== 32'h2) begin n_fail++; $display("FAIL decode_mask_kept: got %h want 2", bus.rd_data); end
        bus_rd(BASE + GPIO_IN_EDGE); tick();
        n_checks++; if (bus.rd_data !== 32'h1) begin n_fail++; $display("FAIL decode_edge_kept: got %h want 1", bus.rd_data); end
        bus.rd_en = 1; bus.wr_en = 1; bus.addr = BASE + GPIO_IN_MASK; bus.wr_data = 8'h0A; tick();
        n_checks++; if (bus.rd_data !== 32'h2) begin n_fail++; $display("FAIL rdwr_prewrite: got %h want 2", bus.rd_data); end
        bus_rd(BASE + 32'hE); tick();
        n_checks++; if (bus.rd_data !== 32'hA) begin n_fail++; $display("FAIL rdwr_written_lane: got %h want a", bus.rd_data); end
        bus_rd(BASE + GPIO_IN_RAW); tick();
        n_checks++; if (bus.rd_data !== 32'h7) begin n_fail++; $display("FAIL raw_read: got %h want 7", bus.rd_data); end
        bus_idle();
    endtask

    task automatic test_random();
        logic [31:0] addrs [6];
        addrs[0] = BASE; addrs[1] = BASE + 4; addrs[2] = BASE + 8; addrs[3] = BASE + 12;
        addrs[4] = BASE + 32'h10; addrs[5] = 32'h0001_0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) pin_i = pin_i ^ 8'($urandom);
            bus.addr    = addrs[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
            bus.rd_en   = ($urandom_range(0, 1) == 1);
            bus.wr_en   = ($urandom_range(0, 7) == 0);
            bus.wr_data = 8'($urandom);
            tick();
            n_checks++; if (bus.rd_data !== m_rd_data) begin n_fail++; $display("FAIL rand_rd_data c=%0d: got %h want %h", c, bus.rd_data, m_rd_data); end
            n_checks++; if (bus.rd_hit !== m_rd_hit) begin n_fail++; $display("FAIL rand_rd_hit c=%0d: got %b want %b", c, bus.rd_hit, m_rd_hit); end
            n_checks++; if (irq !== m_irq) begin n_fail++; $display("FAIL rand_irq c=%0d: got %b want %b", c, irq, m_irq); end
        end
        bus_idle();
    endtask

    task automatic test_reset_midcount();
        bus_wr(BASE + GPIO_IN_MASK, 8'hFF); pin_i = 8'h00; tick();
        bus_idle(); repeat (8) tick();
        bus_wr(BASE + GPIO_IN_EDGE, 8'hFF); tick();
        pin_i = 8'h10; bus_rd(BASE + GPIO_IN_MASK);
        repeat (4) tick();
        n_checks++; if (bus.rd_data !== 32'hFF || bus.rd_hit !== 1'b1) begin n_fail++; $display("FAIL midcount_pre: got %h/%b want ff/1", bus.rd_data, bus.rd_hit); end
        #2; rst_n = 0; #1;
        n_checks++; if (bus.rd_data !== 32'h0 || bus.rd_hit !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL midcount_async: got %h/%b/%b want 0/0/0", bus.rd_data, bus.rd_hit, irq); end
        @(posedge clk); #1;
        rst_n = 1; model_reset();
        bus_rd(BASE + GPIO_IN_EDGE);
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++; if (bus.rd_data !== m_rd_data) begin n_fail++; $display("FAIL requal_model k=%0d: got %h want %h", k, bus.rd_data, m_rd_data); end
            if (k == 6) begin
                n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL requal_early: got %h want 0", bus.rd_data); end
            end
            if (k == 7) begin
                n_checks++; if (bus.rd_data !== 32'h10) begin n_fail++; $display("FAIL requal_edge: got %h want 10", bus.rd_data); end
            end
        end
        bus_rd(BASE + GPIO_IN_MASK); tick();
        n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL midcount_mask: got %h want 0", bus.rd_data); end
        bus_idle();
    endtask

    initial begin
        bus_idle();
        model_reset();
        test_reset();
        test_latency();
        test_glitch();
        test_edge_w1c();
        test_irq();
        test_decode();
        test_random();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
